// File: rtl/flash_reader_pkg.sv
// Shared types and widths for the flash sample reader.
// Covers the FSM state encoding, the bus widths and the sample half-word selection.
package flash_reader_pkg;

    localparam int ADDR_W_DEFAULT = 23;
    localparam int SAMPLE_W       = 16;
    localparam int WORD_W         = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        EMIT_FIRST,
        EMIT_SECOND,
        DONE
    } state_t;

    // Returns the upper or lower 16-bit audio sample packed in a 32-bit flash word.
    function automatic logic [SAMPLE_W-1:0] pick_half(
        input logic [WORD_W-1:0] word,
        input logic              upper
    );
        return upper ? word[WORD_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/flash_timeout_ctr.sv
// Loadable down-counter that flags when it has reached zero.
// The module only exists when FLASH_TIMEOUT_EN is defined.
`ifdef FLASH_TIMEOUT_EN
module flash_timeout_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Count saturates at zero so a late enable cannot wrap it back to a large value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule
`endif

// File: rtl/flash_sample_reader.sv
// Reads one 32-bit flash word over Avalon-MM and emits it as two 16-bit samples.
// Optional read timeout is enabled by defining FLASH_TIMEOUT_EN.
module flash_sample_reader
    import flash_reader_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   address,
    input  logic [1:0]          direction,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [3:0]          flash_mem_byteenable,
    input  logic                flash_mem_waitrequest,
    input  logic [WORD_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                done,
    output logic                busy,
    output logic                error
);

    state_t              state;
    state_t              next_state;
    logic                reverse_q;
    logic                next_reverse;
    logic [WORD_W-1:0]   word_q;
    logic [WORD_W-1:0]   next_word;
    logic [ADDR_W-1:0]   next_addr;
    logic [SAMPLE_W-1:0] next_sample;
    logic                next_read;
    logic                next_sample_valid;
    logic                next_done;
    logic                next_busy;

`ifdef FLASH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic timeout_load;
    logic timeout_hit;
    logic timeout_zero;

    // Loaded with N-1 on entering WAIT_DATA so that expiry lands on the N-th dwell cycle.
    flash_timeout_ctr #(
        .WIDTH(CNT_W)
    ) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timeout_load),
        .load_value (CNT_W'(TIMEOUT_CYCLES - 1)),
        .enable     ((state == WAIT_DATA) && !flash_mem_readdatavalid),
        .zero       (timeout_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else begin
            error <= timeout_hit;
        end
    end
`else
    assign error = 1'b0;
`endif

    assign flash_mem_byteenable = 4'b1111;

    // Outputs are computed from the next state so every output comes straight from a flop.
    always_comb begin
        next_state        = state;
        next_reverse      = reverse_q;
        next_word         = word_q;
        next_addr         = flash_mem_address;
        next_sample       = sample;
        next_sample_valid = 1'b0;
        next_done         = 1'b0;
`ifdef FLASH_TIMEOUT_EN
        timeout_load      = 1'b0;
        timeout_hit       = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (start && direction[1]) begin
                    next_state   = REQ;
                    next_addr    = address;
                    next_reverse = direction[0];
                end
            end
            REQ: begin
                if (!flash_mem_waitrequest) begin
                    next_state = WAIT_DATA;
`ifdef FLASH_TIMEOUT_EN
                    timeout_load = 1'b1;
`endif
                end
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    next_state        = EMIT_FIRST;
                    next_word         = flash_mem_readdata;
                    next_sample       = pick_half(flash_mem_readdata, reverse_q);
                    next_sample_valid = 1'b1;
                end
`ifdef FLASH_TIMEOUT_EN
                else if (timeout_zero) begin
                    next_state  = IDLE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            EMIT_FIRST: begin
                next_state        = EMIT_SECOND;
                next_sample       = pick_half(word_q, !reverse_q);
                next_sample_valid = 1'b1;
            end
            EMIT_SECOND: begin
                next_state = DONE;
                next_done  = 1'b1;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        next_read = (next_state == REQ);
        next_busy = (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            reverse_q         <= 1'b0;
            word_q            <= '0;
            flash_mem_address <= '0;
            flash_mem_read    <= 1'b0;
            sample            <= '0;
            sample_valid      <= 1'b0;
            done              <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= next_state;
            reverse_q         <= next_reverse;
            word_q            <= next_word;
            flash_mem_address <= next_addr;
            flash_mem_read    <= next_read;
            sample            <= next_sample;
            sample_valid      <= next_sample_valid;
            done              <= next_done;
            busy              <= next_busy;
        end
    end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed, table-driven testbench for flash_sample_reader with an Avalon slave driven by hand.
// Timeout checks run only when FLASH_TIMEOUT_EN is defined.
module tb_flash_sample_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [22:0] address = '0;
    logic [1:0]  direction = 2'b00;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = '0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic [15:0] sample;
    logic        sample_valid;
    logic        done;
    logic        busy;
    logic        error;

    int total_checks = 0;
    int passed_checks = 0;

    flash_sample_reader #(
        .ADDR_W         (23),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .address                 (address),
        .direction               (direction),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .sample                  (sample),
        .sample_valid            (sample_valid),
        .done                    (done),
        .busy                    (busy),
        .error                   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] addr;
        logic [1:0]  dir;
        logic [31:0] data;
        int          stall;
        logic        start_in_emit;
        logic [15:0] exp_first;
        logic [15:0] exp_second;
    } vector_t;

    vector_t vectors [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_read"},   32'(flash_mem_read),    32'd0);
        checkOutput({tag, "_addr"},   32'(flash_mem_address), 32'd0);
        checkOutput({tag, "_sample"}, 32'(sample),            32'd0);
        checkOutput({tag, "_valid"},  32'(sample_valid),      32'd0);
        checkOutput({tag, "_done"},   32'(done),              32'd0);
        checkOutput({tag, "_busy"},   32'(busy),              32'd0);
        checkOutput({tag, "_error"},  32'(error),             32'd0);
    endtask

    // One complete read: start at edge N, optional stall, data returned one cycle after acceptance.
    task automatic applyStimulus(input vector_t v);
        start     = 1'b1;
        address   = v.addr;
        direction = v.dir;
        tick();
        start     = 1'b0;
        address   = ~v.addr;
        direction = ~v.dir;
        flash_mem_waitrequest = (v.stall != 0);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < v.stall; i++) begin
            checkOutput("read_stall", 32'(flash_mem_read), 32'd1);
            checkOutput("addr_stall", 32'(flash_mem_address), 32'(v.addr));
            tick();
        end
        flash_mem_waitrequest = 1'b0;
        checkOutput("read_accept", 32'(flash_mem_read), 32'd1);
        checkOutput("addr_accept", 32'(flash_mem_address), 32'(v.addr));
        checkOutput("byteenable", 32'(flash_mem_byteenable), 32'hF);
        tick();
        checkOutput("read_dropped", 32'(flash_mem_read), 32'd0);
        checkOutput("no_early_valid", 32'(sample_valid), 32'd0);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = v.data;
        tick();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h5A5A_A5A5;
        checkOutput("first_valid", 32'(sample_valid), 32'd1);
        checkOutput("first_sample", 32'(sample), 32'(v.exp_first));
        if (v.start_in_emit) begin
            start     = 1'b1;
            address   = 23'h000777;
            direction = 2'b10;
        end
        tick();
        start = 1'b0;
        checkOutput("second_valid", 32'(sample_valid), 32'd1);
        checkOutput("second_sample", 32'(sample), 32'(v.exp_second));
        checkOutput("done_early", 32'(done), 32'd0);
        tick();
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("valid_after", 32'(sample_valid), 32'd0);
        checkOutput("sample_hold", 32'(sample), 32'(v.exp_second));
        checkOutput("busy_in_done", 32'(busy), 32'd1);
        tick();
        checkOutput("done_cleared", 32'(done), 32'd0);
        checkOutput("busy_cleared", 32'(busy), 32'd0);
        checkOutput("error_low", 32'(error), 32'd0);
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_read", 32'(flash_mem_read), 32'd0);
    endtask

    initial begin
        vectors[0] = '{23'h000010, 2'b10, 32'hBEEF_CAFE, 0, 1'b0, 16'hCAFE, 16'hBEEF};
        vectors[1] = '{23'h000010, 2'b11, 32'hBEEF_CAFE, 0, 1'b0, 16'hBEEF, 16'hCAFE};
        vectors[2] = '{23'h7FFFFF, 2'b10, 32'h1234_5678, 5, 1'b1, 16'h5678, 16'h1234};
        vectors[3] = '{23'h000000, 2'b11, 32'h0000_FFFF, 2, 1'b0, 16'h0000, 16'hFFFF};

        #1 reset_n = 1'b0;
        #2;
        checkIdleZero("reset");
        repeat (2) @(posedge clk);
        #4 reset_n = 1'b1;
        tick();

        // A start while playback is paused must not begin a transaction.
        start     = 1'b1;
        address   = 23'h000005;
        direction = 2'b00;
        tick();
        start = 1'b0;
        checkOutput("paused_busy", 32'(busy), 32'd0);
        checkOutput("paused_read", 32'(flash_mem_read), 32'd0);
        tick();
        checkOutput("paused_busy_hold", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i]);
        end

        // Reset asserted while waiting for data, then a stray readdatavalid after release.
        start     = 1'b1;
        address   = 23'h000042;
        direction = 2'b10;
        tick();
        start = 1'b0;
        tick();
        checkOutput("wait_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkIdleZero("midreset");
        @(posedge clk);
        #2;
        checkIdleZero("midreset_hold");
        reset_n = 1'b1;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h1111_2222;
        tick();
        flash_mem_readdatavalid = 1'b0;
        checkIdleZero("stray_rdv");
        tick();
        checkIdleZero("stray_rdv_hold");

`ifdef FLASH_TIMEOUT_EN
        start     = 1'b1;
        address   = 23'h000100;
        direction = 2'b10;
        tick();
        start = 1'b0;
        tick();
        checkOutput("to_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("to_error_early", 32'(error), 32'd0);
            checkOutput("to_busy_wait", 32'(busy), 32'd1);
        end
        tick();
        checkOutput("to_error_pulse", 32'(error), 32'd1);
        checkOutput("to_busy_idle", 32'(busy), 32'd0);
        checkOutput("to_done_low", 32'(done), 32'd0);
        checkOutput("to_valid_low", 32'(sample_valid), 32'd0);
        tick();
        checkOutput("to_error_cleared", 32'(error), 32'd0);
        checkOutput("to_done_still_low", 32'(done), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
